// File: rtl/scroll_provider_if.sv
// Row-byte stream from the glyph-frame source to the MAX7219 serializer.
// The master drives one row byte per device and holds it until out_ready accepts it.
interface scroll_provider_if #(
  parameter int DEV_W = 2
);
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [2:0]       out_row;
  logic [DEV_W-1:0] out_dev;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_row, out_dev, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_dev, out_last,
    output out_ready
  );
endinterface

// File: rtl/scroll_provider.sv
// Glyph-frame source for N_DEV cascaded MAX7219 matrices: reads a message of glyph codes,
// fetches two glyphs per row byte from a sync ROM and streams static / page / pixel-scroll frames.
module scroll_provider #(
  parameter int          N_DEV      = 4,
  parameter int          MSG_LEN    = 16,
  parameter int          STEP_DIV   = 8,
  parameter logic [7:0]  BLANK_CODE = 8'd127,
  localparam int L     = MSG_LEN * 8,
  localparam int OFF_W = $clog2(L),
  localparam int VW    = OFF_W + 1,
  localparam int AW    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
  localparam int DEV_W = (N_DEV > 1) ? $clog2(N_DEV) : 1,
  localparam int FC_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [1:0]        mode,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rom_addr,
  input  logic [63:0]       rom_q,
  scroll_provider_if.master stream
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_A    = 3'd1,
    S_RD_B    = 3'd2,
    S_CAP     = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [7:0]        r_msg [MSG_LEN];
  logic [OFF_W-1:0]  r_offset;
  logic [FC_W-1:0]   r_frame_cnt;
  logic [2:0]        r_row;
  logic [DEV_W-1:0]  r_dev;
  logic [63:0]       r_glyph_a;
  logic [7:0]        r_rom_hold;

  logic              r_out_valid;
  logic [7:0]        r_out_data;
  logic [2:0]        r_out_row;
  logic [DEV_W-1:0]  r_out_dev;
  logic              r_out_last;

  logic [VW-1:0]     w_v_sum;
  logic [VW-1:0]     w_v0;
  logic [AW-1:0]     w_a;
  logic [AW-1:0]     w_b;
  logic [2:0]        w_s;
  logic [7:0]        w_comb;
  logic [VW-1:0]     w_off_sum;
  logic [OFF_W-1:0]  w_off_next;
  logic              w_accept;

  // Message store; a read in the same cycle as a write still sees the old code.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_msg[i] <= BLANK_CODE;
      end
    end else if (wr_en) begin
      r_msg[wr_addr] <= wr_data;
    end
  end

  // Virtual column of this device's leftmost pixel; offset + 8*dev < 2L, so one subtract wraps it.
  assign w_v_sum = {1'b0, r_offset} + VW'(8 * int'(r_dev));
  assign w_v0    = (w_v_sum >= VW'(L)) ? (w_v_sum - VW'(L)) : w_v_sum;
  assign w_a     = AW'(w_v0 >> 3);
  assign w_b     = (w_a == AW'(MSG_LEN - 1)) ? '0 : (w_a + 1'b1);
  assign w_s     = w_v0[2:0];

  // Column x takes glyph A column x+s, spilling into glyph B (now on rom_q) once x+s passes 7.
  // Both cases reduce to the same in-glyph bit index {~c[2:0], row}.
  for (genvar gi = 0; gi < 8; gi++) begin : g_col
    logic [3:0] w_c;
    logic [5:0] w_idx;
    assign w_c            = 4'(gi) + {1'b0, w_s};
    assign w_idx          = {~w_c[2:0], r_row};
    assign w_comb[7 - gi] = w_c[3] ? rom_q[w_idx] : r_glyph_a[w_idx];
  end

  always_comb begin
    w_off_sum  = {1'b0, r_offset} + ((mode == 2'd1) ? VW'(8) : VW'(1));
    w_off_next = (w_off_sum >= VW'(L)) ? OFF_W'(w_off_sum - VW'(L)) : OFF_W'(w_off_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (run) w_state_next = S_RD_A;
      S_RD_A:    w_state_next = S_RD_B;
      S_RD_B:    w_state_next = S_CAP;
      S_CAP:     w_state_next = S_PRESENT;
      S_PRESENT: if (stream.out_ready) w_state_next = run ? S_RD_A : S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Outside the two read states the address parks on glyph B, so the ROM output stays put.
  always_comb begin
    w_accept = (r_state == S_PRESENT) && stream.out_ready;
    rom_addr = r_rom_hold;
    case (r_state)
      S_RD_A:  rom_addr = r_msg[w_a];
      S_RD_B:  rom_addr = r_msg[w_b];
      default: rom_addr = r_rom_hold;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_offset    <= '0;
      r_frame_cnt <= '0;
      r_row       <= '0;
      r_dev       <= DEV_W'(N_DEV - 1);
      r_glyph_a   <= '0;
      r_rom_hold  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_dev   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_row <= '0;
          r_dev <= DEV_W'(N_DEV - 1);
        end
        S_RD_B: begin
          r_glyph_a  <= rom_q;
          r_rom_hold <= r_msg[w_b];
        end
        S_CAP: begin
          r_out_data  <= w_comb;
          r_out_valid <= 1'b1;
          r_out_row   <= r_row;
          r_out_dev   <= r_dev;
          r_out_last  <= (r_row == 3'd7) && (r_dev == '0);
        end
        default: ;
      endcase

      if (w_accept) begin
        r_out_valid <= 1'b0;
        if (r_dev == '0) begin
          r_dev <= DEV_W'(N_DEV - 1);
          r_row <= r_row + 3'd1;
        end else begin
          r_dev <= r_dev - 1'b1;
        end
        // Frame boundary: the mode present now decides how the next frame is positioned.
        if (r_out_last) begin
          if (mode == 2'd1 || mode == 2'd2) begin
            if (r_frame_cnt == FC_W'(STEP_DIV - 1)) begin
              r_frame_cnt <= '0;
              r_offset    <= w_off_next;
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end else begin
            r_offset <= '0;
          end
        end
      end
    end
  end

  assign stream.out_valid = r_out_valid;
  assign stream.out_data  = r_out_data;
  assign stream.out_row   = r_out_row;
  assign stream.out_dev   = r_out_dev;
  assign stream.out_last  = r_out_last;

endmodule

// File: tb/tb_scroll_provider.sv
// Self-checking bench for scroll_provider: random message and ROM contents, compared against
// a column-level model of the frame stream (virtual column = offset + 8*dev + x, mod L).
module tb_scroll_provider;
  localparam int N_DEV    = 2;
  localparam int MSG_LEN  = 4;
  localparam int STEP_DIV = 1;
  localparam int L        = MSG_LEN * 8;
  localparam int AW       = 2;
  localparam int FBYTES   = 8 * N_DEV;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [1:0]    mode;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    rom_addr;
  logic [63:0]   rom_q;

  scroll_provider_if #(.DEV_W(1)) sif ();

  scroll_provider #(
    .N_DEV(N_DEV), .MSG_LEN(MSG_LEN), .STEP_DIV(STEP_DIV), .BLANK_CODE(8'd127)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .mode(mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rom_addr(rom_addr), .rom_q(rom_q), .stream(sif)
  );

  always #5 clk = ~clk;

  logic [63:0] rom_tbl [256];
  always @(posedge clk) rom_q <= rom_tbl[rom_addr];

  int checks = 0;
  int errors = 0;

  logic [7:0] m_msg [MSG_LEN];
  int m_off, m_fcnt, m_k;

  function automatic logic [7:0] model_byte(int off, int k);
    logic [7:0]  b;
    logic [7:0]  g;
    logic [63:0] glyph;
    int row, dev, c;
    row = k / N_DEV;
    dev = N_DEV - 1 - (k % N_DEV);
    b = '0;
    for (int x = 0; x < 8; x++) begin
      c = (off + 8 * dev + x) % L;
      g = m_msg[c / 8];
      glyph = rom_tbl[g];
      b[7 - x] = glyph[8 * (7 - (c % 8)) + row];
    end
    return b;
  endfunction

  task automatic model_accept();
    if (m_k == FBYTES - 1) begin
      m_k = 0;
      if (mode == 2'd1 || mode == 2'd2) begin
        if (m_fcnt == STEP_DIV - 1) begin
          m_fcnt = 0;
          m_off = (m_off + ((mode == 2'd1) ? 8 : 1)) % L;
        end else begin
          m_fcnt++;
        end
      end else begin
        m_off = 0;
      end
    end else begin
      m_k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mode = 2'd0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sif.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < MSG_LEN; i++) m_msg[i] = 8'd127;
    m_off = 0; m_fcnt = 0; m_k = 0;
  endtask

  task automatic write_msg_random();
    for (int i = 0; i < MSG_LEN; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'($urandom);
      m_msg[i] = wr_data;
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sif.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    do_reset();
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sif.out_valid); end
    checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (sif.out_data !== 8'd0 || sif.out_row !== 3'd0 || sif.out_dev !== 1'b0 || sif.out_last !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got data=%02h row=%0d dev=%0d last=%b expected all 0",
                         sif.out_data, sif.out_row, sif.out_dev, sif.out_last);
    end
    mode = 2'd0; run = 1'b1;
    @(negedge clk);
    checks++; if (rom_addr !== 8'd127) begin errors++; $display("FAIL first_rom_a: got %0d expected 127", rom_addr); end
    @(negedge clk);
    checks++; if (rom_addr !== 8'd127) begin errors++; $display("FAIL first_rom_b: got %0d expected 127", rom_addr); end
    @(negedge clk);
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid: got %b expected 0", sif.out_valid); end
    @(negedge clk);
    checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL first_latency: got valid=%b expected 1", sif.out_valid); end
    exp = model_byte(m_off, m_k);
    checks++; if (sif.out_data !== exp || sif.out_row !== 3'd0 || sif.out_dev !== 1'b1) begin
      errors++; $display("FAIL first_byte: got data=%02h row=%0d dev=%0d expected data=%02h row=0 dev=1",
                         sif.out_data, sif.out_row, sif.out_dev, exp);
    end
    $display("reset: first byte data=%02h row=%0d dev=%0d", sif.out_data, sif.out_row, sif.out_dev);
    run = 1'b0;
    model_accept();
    @(negedge clk);
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL first_release: got %b expected 0", sif.out_valid); end
  endtask

  task automatic test_modes();
    logic [1:0] mode_list [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    int         frame_list [4] = '{2, 34, 5, 2};
    logic [7:0] exp;
    bit ok;
    do_reset();
    write_msg_random();
    run = 1'b1;
    for (int e = 0; e < 4; e++) begin
      mode = mode_list[e];
      for (int b = 0; b < frame_list[e] * FBYTES; b++) begin
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL modes_timeout: got no out_valid expected a byte (mode %0d)", mode); return; end
        exp = model_byte(m_off, m_k);
        checks++; if (sif.out_data !== exp) begin
          errors++; $display("FAIL modes_data mode=%0d off=%0d k=%0d: got %02h expected %02h", mode, m_off, m_k, sif.out_data, exp);
        end
        checks++; if (sif.out_row !== 3'(m_k / N_DEV) || sif.out_dev !== 1'(N_DEV - 1 - m_k % N_DEV)) begin
          errors++; $display("FAIL modes_pos k=%0d: got row=%0d dev=%0d expected row=%0d dev=%0d",
                             m_k, sif.out_row, sif.out_dev, m_k / N_DEV, N_DEV - 1 - m_k % N_DEV);
        end
        checks++; if (sif.out_last !== (m_k == FBYTES - 1)) begin
          errors++; $display("FAIL modes_last k=%0d: got %b expected %b", m_k, sif.out_last, (m_k == FBYTES - 1));
        end
        $display("mode=%0d off=%0d k=%0d row=%0d dev=%0d data=%02h last=%b",
                 mode, m_off, m_k, sif.out_row, sif.out_dev, sif.out_data, sif.out_last);
        model_accept();
        @(negedge clk);
      end
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    bit ok;
    int gap;
    do_reset();
    write_msg_random();
    mode = 2'd2; run = 1'b1;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no out_valid expected a byte"); return; end
    for (int b = 0; b < 20; b++) begin
      exp = model_byte(m_off, m_k);
      checks++; if (sif.out_data !== exp) begin
        errors++; $display("FAIL b2b_data k=%0d: got %02h expected %02h", m_k, sif.out_data, exp);
      end
      $display("b2b off=%0d k=%0d data=%02h", m_off, m_k, sif.out_data);
      model_accept();
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (sif.out_valid !== 1'b1 && gap < 40);
      checks++; if (gap != 4) begin errors++; $display("FAIL b2b_gap k=%0d: got %0d cycles expected 4", m_k, gap); end
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp, hold_data, hold_addr;
    int stall;
    bit ok;
    do_reset();
    write_msg_random();
    mode = 2'd2; run = 1'b1;
    for (int b = 0; b < 48; b++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no out_valid expected a byte"); return; end
      exp = model_byte(m_off, m_k);
      stall = (b == 2) ? 5 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      hold_data = sif.out_data;
      hold_addr = rom_addr;
      sif.out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checks++; if (sif.out_valid !== 1'b1 || sif.out_data !== hold_data || rom_addr !== hold_addr) begin
          errors++; $display("FAIL bp_hold k=%0d: got valid=%b data=%02h rom=%0d expected valid=1 data=%02h rom=%0d",
                             m_k, sif.out_valid, sif.out_data, rom_addr, hold_data, hold_addr);
        end
      end
      sif.out_ready = 1'b1;
      checks++; if (sif.out_data !== exp || sif.out_last !== (m_k == FBYTES - 1)) begin
        errors++; $display("FAIL bp_data k=%0d: got data=%02h last=%b expected data=%02h last=%b",
                           m_k, sif.out_data, sif.out_last, exp, (m_k == FBYTES - 1));
      end
      $display("bp stall=%0d off=%0d k=%0d data=%02h", stall, m_off, m_k, sif.out_data);
      model_accept();
      @(negedge clk);
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_run_drop();
    logic [7:0] exp;
    bit ok;
    do_reset();
    write_msg_random();
    mode = 2'd2; run = 1'b1;
    // Complete one frame so the restart happens at a non-zero offset.
    for (int b = 0; b < FBYTES + 5; b++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_timeout: got no out_valid expected a byte"); return; end
      exp = model_byte(m_off, m_k);
      checks++; if (sif.out_data !== exp) begin
        errors++; $display("FAIL drop_data k=%0d: got %02h expected %02h", m_k, sif.out_data, exp);
      end
      $display("drop off=%0d k=%0d data=%02h", m_off, m_k, sif.out_data);
      if (b == FBYTES + 4) run = 1'b0;
      model_accept();
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL drop_idle cycle %0d: got valid=%b expected 0", i, sif.out_valid); end
      @(negedge clk);
    end
    m_k = 0;
    run = 1'b1;
    for (int b = 0; b < FBYTES; b++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rerun_timeout: got no out_valid expected a byte"); return; end
      exp = model_byte(m_off, m_k);
      checks++; if (sif.out_data !== exp || sif.out_row !== 3'(m_k / N_DEV) || sif.out_dev !== 1'(N_DEV - 1 - m_k % N_DEV)) begin
        errors++; $display("FAIL rerun_byte k=%0d: got data=%02h row=%0d dev=%0d expected data=%02h row=%0d dev=%0d",
                           m_k, sif.out_data, sif.out_row, sif.out_dev, exp, m_k / N_DEV, N_DEV - 1 - m_k % N_DEV);
      end
      $display("rerun off=%0d k=%0d data=%02h", m_off, m_k, sif.out_data);
      model_accept();
      @(negedge clk);
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_rst_mid();
    logic [7:0] exp;
    bit ok;
    do_reset();
    write_msg_random();
    mode = 2'd2; run = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wait_valid(ok);
      model_accept();
      @(negedge clk);
    end
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: got no out_valid expected a byte"); return; end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sif.out_valid !== 1'b0 || sif.out_data !== 8'd0 || sif.out_row !== 3'd0 ||
                  sif.out_dev !== 1'b0 || sif.out_last !== 1'b0 || rom_addr !== 8'd0) begin
      errors++; $display("FAIL rstmid_outputs: got valid=%b data=%02h row=%0d dev=%0d last=%b rom=%0d expected all 0",
                         sif.out_valid, sif.out_data, sif.out_row, sif.out_dev, sif.out_last, rom_addr);
    end
    rst = 1'b0;
    for (int i = 0; i < MSG_LEN; i++) m_msg[i] = 8'd127;
    m_off = 0; m_fcnt = 0; m_k = 0;
    for (int b = 0; b < 4; b++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_rerun_timeout: got no out_valid expected a byte"); return; end
      exp = model_byte(m_off, m_k);
      checks++; if (sif.out_data !== exp) begin
        errors++; $display("FAIL rstmid_blank k=%0d: got %02h expected %02h", m_k, sif.out_data, exp);
      end
      $display("rstmid off=%0d k=%0d data=%02h", m_off, m_k, sif.out_data);
      model_accept();
      @(negedge clk);
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_tbl[i] = {$urandom, $urandom};
    rst = 1'b1; run = 1'b0; mode = 2'd0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sif.out_ready = 1'b1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_run_drop();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
